tx_frame_sender: RTL and testbench

FPGA-side consumer of the HPS transmit path. It buffers the payload bytes that the HPS bus driver writes over `data_tx`/`wren_fifo_tx`. On a `start_tx` pulse it serializes a framed packet onto a single-bit line: preamble, sync, length, payload, XOR checksum. It reports `ready_tx` back to the driver and raises a one-cycle completion pulse that feeds the interrupt logic.

---
 rtl/tx_frame_pkg.sv | 16 +
 rtl/tx_byte_fifo.sv | 59 +++++
 rtl/tx_frame_sender.sv | 175 +++++++++++++++++
 tb/tb_tx_frame_sender.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_pkg.sv
// Shared types and default frame constants for the serial frame transmitter.
package tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SYN,
    LEN,
    PAY,
    CHK
  } tx_state_e;

  localparam logic [7:0] DEF_PREAMBLE = 8'hAA;
  localparam logic [7:0] DEF_SYNC     = 8'h7E;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO with first-word-fall-through read: dout always shows the head byte.
// The level counter is one bit wider than the pointers so full and empty differ.
module tx_byte_fifo #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;

  // Occupancy: a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
    end
  end

  // Storage array; no reset needed since the level gates what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_MAX);
  assign empty = (level_q == '0);

endmodule

// File: rtl/tx_frame_sender.sv
// Serial frame transmitter: preamble, sync, length, payload, XOR checksum, MSB first.
//
// state | meaning
// IDLE  | waiting for an acceptable start, ready_tx high
// PRE   | shifting out the preamble byte
// SYN   | shifting out the sync byte
// LEN   | shifting out the payload length N
// PAY   | shifting out N payload bytes popped from the FIFO
// CHK   | shifting out N xor all payload bytes
module tx_frame_sender
  import tx_frame_pkg::*;
#(
  parameter  int          CLKS_PER_BIT = 50,
  parameter  int          FIFO_DEPTH   = 256,
  parameter  logic [7:0]  PREAMBLE     = DEF_PREAMBLE,
  parameter  logic [7:0]  SYNC         = DEF_SYNC,
  localparam int          LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    data_tx,
  input  logic          wren_fifo_tx,
  input  logic [7:0]    size_fifo_tx,
  input  logic          start_tx,
  output logic          ready_tx,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  output logic          tx_bit,
  output logic          tx_active,
  output logic          tx_done
);

  // The acceptance cycle counts as the first cycle of the first preamble bit,
  // so the frame ends exactly (4+N)*8*CLKS_PER_BIT cycles after acceptance.
  localparam logic [15:0] BIT_LOAD   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] FIRST_LOAD = 16'(CLKS_PER_BIT - 2);

  tx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    chk_q, chk_d;
  logic [2:0]    bit_q, bit_d;
  logic [15:0]   tmr_q, tmr_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [LW-1:0] level;
  logic          start_ok, tick;

  tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data_tx),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign start_ok  = (state_q == IDLE) && start_tx && (size_fifo_tx != 8'd0) &&
                     (32'(size_fifo_tx) <= 32'(level));
  assign tick      = (tmr_q == 16'd0);
  assign fifo_push = wren_fifo_tx && (!fifo_full || fifo_pop);

  // Frame sequencing, bit engine and checksum accumulation.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    len_d    = len_q;
    rem_d    = rem_q;
    chk_d    = chk_q;
    bit_d    = bit_q;
    tmr_d    = tmr_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    if (state_q == IDLE) begin
      if (start_ok) begin
        state_d = PRE;
        shift_d = PREAMBLE;
        bit_d   = 3'd0;
        tmr_d   = FIRST_LOAD;
        len_d   = size_fifo_tx;
        chk_d   = size_fifo_tx;
      end
    end else if (!tick) begin
      tmr_d = tmr_q - 16'd1;
    end else begin
      tmr_d = BIT_LOAD;
      if (bit_q != 3'd7) begin
        shift_d = {shift_q[6:0], 1'b0};
        bit_d   = bit_q + 3'd1;
      end else begin
        bit_d = 3'd0;
        case (state_q)
          PRE: begin
            state_d = SYN;
            shift_d = SYNC;
          end
          SYN: begin
            state_d = LEN;
            shift_d = len_q;
          end
          LEN: begin
            state_d  = PAY;
            shift_d  = fifo_dout;
            fifo_pop = !fifo_empty;
            chk_d    = chk_q ^ fifo_dout;
            rem_d    = len_q - 8'd1;
          end
          PAY: begin
            if (rem_q == 8'd0) begin
              state_d = CHK;
              shift_d = chk_q;
            end else begin
              shift_d  = fifo_dout;
              fifo_pop = !fifo_empty;
              chk_d    = chk_q ^ fifo_dout;
              rem_d    = rem_q - 8'd1;
            end
          end
          CHK: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Sticky overflow: a dropped write sets it, an accepted start clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (start_ok) ovf_d = 1'b0;
    if (wren_fifo_tx && !fifo_push) ovf_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      chk_q   <= '0;
      bit_q   <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      chk_q   <= chk_d;
      bit_q   <= bit_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_tx   = (state_q == IDLE);
  assign tx_active  = (state_q != IDLE);
  assign tx_bit     = tx_active & shift_q[7];
  assign tx_done    = done_q;
  assign fifo_level = level;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_tx_frame_sender.sv
// Scoreboard bench for tx_frame_sender: the stimulus side models the FIFO and
// frame contents and queues expected frames; the monitor decodes the line.
module tb_tx_frame_sender;

  localparam int C     = 4;
  localparam int DEPTH = 256;
  localparam int LW    = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data_tx;
  logic          wren_fifo_tx;
  logic [7:0]    size_fifo_tx;
  logic          start_tx;
  logic          ready_tx;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          tx_bit;
  logic          tx_active;
  logic          tx_done;

  tx_frame_sender #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_tx      (data_tx),
    .wren_fifo_tx (wren_fifo_tx),
    .size_fifo_tx (size_fifo_tx),
    .start_tx     (start_tx),
    .ready_tx     (ready_tx),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .tx_bit       (tx_bit),
    .tx_active    (tx_active),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [7:0] m_fifo[$];
  int         pop_times[$];
  bit         m_ovf = 0;
  int         idle_from = 0;
  int         exp_done = 0;
  int         n_done = 0;
  // scoreboard
  logic [7:0] sb_bytes[$];
  int         sb_len[$];
  bit         abort_frame = 0;

  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk) if (tx_done) n_done++;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model decides acceptance/pops/drops from the
  // frame timing rules, then registered outputs are checked after the edge.
  task automatic step(input bit wr, input logic [7:0] d, input bit st, input logic [7:0] sz);
    int c, n, len_cyc;
    bit pop_now, acc;
    logic [7:0] x;
    reset = 1'b0; wren_fifo_tx = wr; data_tx = d; start_tx = st; size_fifo_tx = sz;
    c = cyc;
    acc = st && (c >= idle_from) && (sz != 8'd0) && (int'(sz) <= m_fifo.size());
    pop_now = (pop_times.size() > 0) && (pop_times[0] == c);
    if (acc) begin
      n = int'(sz);
      len_cyc = (4 + n) * 8 * C;
      x = sz;
      sb_len.push_back(n + 4);
      sb_bytes.push_back(8'hAA);
      sb_bytes.push_back(8'h7E);
      sb_bytes.push_back(sz);
      for (int i = 0; i < n; i++) begin
        sb_bytes.push_back(m_fifo[i]);
        x = x ^ m_fifo[i];
        pop_times.push_back(c + (3 + i) * 8 * C - 1);
      end
      sb_bytes.push_back(x);
      idle_from = c + len_cyc;
      m_ovf = 0;
      exp_done++;
    end
    if (pop_now) begin
      void'(pop_times.pop_front());
      void'(m_fifo.pop_front());
    end
    if (wr) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else m_ovf = 1;
    end
    @(posedge clk); #1;
    check("ready_tx", int'(ready_tx), int'(c + 1 >= idle_from));
    check("fifo_level", int'(fifo_level), m_fifo.size());
    check("overflow", int'(overflow), int'(m_ovf));
    if (c + 1 >= idle_from) check("tx_bit_idle", int'(tx_bit), 0);
  endtask

  task automatic do_reset();
    if (cyc < idle_from) begin
      abort_frame = 1;
      exp_done--;
    end
    reset = 1'b1; wren_fifo_tx = 1'b0; start_tx = 1'b0;
    m_fifo.delete();
    pop_times.delete();
    m_ovf = 0;
    idle_from = 0;
    @(posedge clk); #1;
    check("rst_ready", int'(ready_tx), 1);
    check("rst_tx_bit", int'(tx_bit), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_tx_done", int'(tx_done), 0);
    check("rst_active", int'(tx_active), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
  endtask

  task automatic drain();
    while (cyc < idle_from + 3) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Monitor: decode each frame mid-bit and compare against the scoreboard.
  initial begin : monitor
    bit act_prev;
    int t0, nb;
    bit aborted;
    logic [7:0] got;
    logic [7:0] exp_q[$];
    act_prev = 0;
    forever begin
      @(negedge clk);
      if (tx_active && !act_prev) begin
        t0 = cyc - 1;
        aborted = 0;
        if (sb_len.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          nb = sb_len.pop_front();
          exp_q.delete();
          for (int b = 0; b < nb; b++) exp_q.push_back(sb_bytes.pop_front());
          for (int b = 0; b < nb && !aborted; b++) begin
            got = 8'h00;
            for (int k = 0; k < 8; k++) begin
              while (cyc < t0 + (b * 8 + k) * C + 2 && !abort_frame) @(negedge clk);
              if (abort_frame) begin
                aborted = 1;
                break;
              end
              got = {got[6:0], tx_bit};
            end
            if (!aborted) check("frame_byte", int'(got), int'(exp_q[b]));
          end
          if (!aborted) begin
            while (cyc < t0 + nb * 8 * C - 1 && !abort_frame) @(negedge clk);
            if (!abort_frame) begin
              check("last_bit_active", int'(tx_active), 1);
              check("early_done", int'(tx_done), 0);
              @(negedge clk);
              if (!abort_frame) begin
                check("done_pulse", int'(tx_done), 1);
                check("end_active", int'(tx_active), 0);
                check("end_tx_bit", int'(tx_bit), 0);
                check("end_ready", int'(ready_tx), 1);
              end
            end
          end
          abort_frame = 0;
        end
      end
      act_prev = tx_active;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t_acc;
    bit pw, ps;
    reset = 1'b1; wren_fifo_tx = 1'b0; data_tx = 8'h00; start_tx = 1'b0; size_fifo_tx = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", int'(ready_tx), 1);
    check("reset_tx_bit", int'(tx_bit), 0);
    check("reset_active", int'(tx_active), 0);
    check("reset_done", int'(tx_done), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_level", int'(fifo_level), 0);
    reset = 1'b0;

    // basic three-byte frame
    step(1'b1, 8'h01, 1'b0, 8'h00);
    step(1'b1, 8'h02, 1'b0, 8'h00);
    step(1'b1, 8'h03, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 8'd3);
    drain();
    check("done_count_first", n_done, 1);

    // rejected starts: zero length, length above fill level
    step(1'b0, 8'h00, 1'b1, 8'd0);
    step(1'b1, 8'h5A, 1'b0, 8'h00);
    step(1'b1, 8'hC3, 1'b0, 8'h00);
    repeat (3) step(1'b0, 8'h00, 1'b1, 8'd5);
    step(1'b0, 8'h00, 1'b1, 8'd0);

    // fill to capacity, then one dropped write
    while (m_fifo.size() < DEPTH) step(1'b1, 8'($urandom), 1'b0, 8'h00);
    step(1'b1, 8'hEE, 1'b0, 8'h00);
    check("overflow_set", int'(overflow), 1);
    check("level_full", int'(fifo_level), DEPTH);

    // start clears overflow; pushes only on pop cycles keep the FIFO full;
    // a stray start mid-frame is ignored
    t_acc = cyc;
    step(1'b0, 8'h00, 1'b1, 8'd4);
    check("overflow_cleared", int'(overflow), 0);
    while (cyc < idle_from + 1) begin
      pw = (pop_times.size() > 0) && (pop_times[0] == cyc);
      ps = (cyc == t_acc + 50);
      step(pw, 8'($urandom), ps, 8'd1);
    end
    drain();
    check("done_count_full", n_done, 2);

    // reset in the middle of the payload
    t_acc = cyc;
    step(1'b0, 8'h00, 1'b1, 8'd10);
    while (cyc < t_acc + 3 * 8 * C + 10) step(1'b0, 8'h00, 1'b0, 8'h00);
    do_reset();
    repeat (40) step(1'b0, 8'h00, 1'b0, 8'h00);
    check("done_count_abort", n_done, exp_done);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 19) == 0,
           8'($urandom_range(0, 12)));
    drain();

    check("done_count_final", n_done, exp_done);
    check("scoreboard_empty", sb_len.size(), 0);
    check("pops_outstanding", pop_times.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
